// File: rtl/fifo_rd_pkg.sv
// Shared types, constants and helpers for the async-FIFO read-side stream consumer.
package fifo_rd_pkg;

  typedef logic [1:0] buf_cnt_t;

  localparam int                STAT_W   = 32;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  // Bits needed to hold values up to value-1; never returns less than 1.
  function automatic int clog2_safe(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for fifo_rd_stream.
interface fifo_rd_stream_if #(
  parameter int DSIZE = 8
);
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    input  rdata, rempty, m_ready,
    output rinc, m_data, m_valid, m_last
  );

  modport slave (
    output rdata, rempty, m_ready,
    input  rinc, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry registered output buffer: head slot drives the stream, tail slot absorbs
// the one extra pop that can be in flight when downstream stalls.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [DSIZE-1:0] data_o,
  output logic             valid_o,
  output buf_cnt_t         cnt_o
);

  buf_cnt_t         cnt_q,  cnt_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;

  // NOTE: every variable gets its hold value first so no path through the case infers a latch.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      unique case ({push_i, pop_i})
        2'b10: begin
          if (cnt_q == 2'd0) head_d = push_data_i;
          else               tail_d = push_data_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_d = tail_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Count stays put; the new word lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            head_d = push_data_i;
          end else begin
            head_d = tail_q;
            tail_d = push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the data slots are reset so m_data leaves reset at a defined 0; a deeper buffer
  // would normally leave its storage unreset and rely on the valid count alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = (cnt_q != 2'd0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain FIFO consumer: pops into a 2-entry buffer, streams out with burst tagging.
// Optional pop/stall statistics are built when FIFO_RD_STATS_EN is defined.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int BURST_LEN = 16
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              en,
  input  logic              flush,
  fifo_rd_stream_if.master  bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [STAT_W-1:0] pop_cnt,
  output logic [STAT_W-1:0] stall_cnt
`endif
);

  localparam int                BCNT_W    = clog2_safe(BURST_LEN + 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_LEN - 1);

  buf_cnt_t          buf_cnt;
  logic              buf_valid;
  logic [DSIZE-1:0]  buf_data;
  logic              rinc;
  logic              fire;
  logic              last;
  logic [BCNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Pop decision looks only at local state, never at m_ready.
  assign rinc = en & ~bus.rempty & ~flush & (buf_cnt != 2'd2);
  assign fire = buf_valid & bus.m_ready;
  assign last = buf_valid & (beat_cnt_q == LAST_BEAT);

  fifo_rd_skid #(.DSIZE(DSIZE)) u_skid (
    .clk         (rclk),
    .rst_n       (rrst_n),
    .push_i      (rinc),
    .push_data_i (bus.rdata),
    .pop_i       (fire),
    .flush_i     (flush),
    .data_o      (buf_data),
    .valid_o     (buf_valid),
    .cnt_o       (buf_cnt)
  );

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (flush)     beat_cnt_d = '0;
    else if (fire) beat_cnt_d = last ? '0 : beat_cnt_q + BCNT_W'(1);
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) beat_cnt_q <= '0;
    else         beat_cnt_q <= beat_cnt_d;
  end

  assign bus.rinc    = rinc;
  assign bus.m_data  = buf_data;
  assign bus.m_valid = buf_valid;
  assign bus.m_last  = last;

`ifdef FIFO_RD_STATS_EN
  logic [STAT_W-1:0] pop_cnt_q, stall_cnt_q;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else if (flush) begin
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (rinc && pop_cnt_q != STAT_MAX)
        pop_cnt_q <= pop_cnt_q + 1'b1;
      if (buf_valid && !bus.m_ready && stall_cnt_q != STAT_MAX)
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign pop_cnt   = pop_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read port (BURST_LEN=4).
module tb_fifo_rd_stream;
  import fifo_rd_pkg::*;

  localparam int DSIZE = 8;

  logic rclk;
  logic rrst_n;
  logic en;
  logic flush;

  fifo_rd_stream_if #(.DSIZE(DSIZE)) bus ();

`ifdef FIFO_RD_STATS_EN
  logic [STAT_W-1:0] pop_cnt;
  logic [STAT_W-1:0] stall_cnt;
`endif

  fifo_rd_stream #(.DSIZE(DSIZE), .BURST_LEN(4)) dut (
    .rclk   (rclk),
    .rrst_n (rrst_n),
    .en     (en),
    .flush  (flush),
    .bus    (bus)
`ifdef FIFO_RD_STATS_EN
    ,
    .pop_cnt   (pop_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // Behavioural FIFO: head word is X whenever it is empty.
  logic [DSIZE-1:0] fifo_mem [0:63];
  int unsigned      rd_ptr;
  int unsigned      wr_ptr;

  assign bus.rempty = (rd_ptr == wr_ptr);
  assign bus.rdata  = bus.rempty ? 'x : fifo_mem[rd_ptr[5:0]];

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n)       rd_ptr <= wr_ptr;
    else if (bus.rinc) rd_ptr <= rd_ptr + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rclk);
    @(negedge rclk);
  endtask

  task automatic push(input logic [DSIZE-1:0] d);
    fifo_mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic apply_reset();
    rrst_n      = 1'b0;
    en          = 1'b0;
    flush       = 1'b0;
    bus.m_ready = 1'b0;
    step();
    step();
    rrst_n = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int waited;
    waited = 0;
    while (!bus.m_valid && waited < budget) begin
      step();
      waited++;
    end
    check(tag, {31'd0, bus.m_valid}, 32'd1);
  endtask

  initial begin
    int pulses;
    wr_ptr      = 0;
    rrst_n      = 1'b0;
    en          = 1'b0;
    flush       = 1'b0;
    bus.m_ready = 1'b0;

    // Reset state
    apply_reset();
    check("rst_rinc",    {31'd0, bus.rinc},    32'd0);
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    check("rst_m_last",  {31'd0, bus.m_last},  32'd0);
    check("rst_m_data",  {24'd0, bus.m_data},  32'd0);

    // Three words, downstream always ready
    en = 1'b1;
    bus.m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    #1;
    check("t1_rinc_first", {31'd0, bus.rinc},    32'd1);
    check("t1_valid_first", {31'd0, bus.m_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_valid", {31'd0, bus.m_valid}, 32'd1);
      check("t1_data",  {24'd0, bus.m_data},  32'(8'h11 * (i + 1)));
      check("t1_rinc",  {31'd0, bus.rinc},    (i < 2) ? 32'd1 : 32'd0);
    end
    step();
    check("t1_valid_end", {31'd0, bus.m_valid}, 32'd0);

    // Back-pressure: buffer fills after two pops, head held, then drains gap-free
    apply_reset();
    en = 1'b1;
    for (int i = 0; i < 5; i++) push(8'hA1 + 8'(i));
    #1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      pulses += int'(bus.rinc);
      step();
      check("t2_hold_data", {24'd0, bus.m_data}, 32'hA1);
    end
    check("t2_rinc_pulses", 32'(pulses), 32'd2);
    bus.m_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("t2_drain_valid", {31'd0, bus.m_valid}, 32'd1);
      check("t2_drain_data",  {24'd0, bus.m_data},  32'(8'hA1 + k));
      step();
    end
    check("t2_valid_end", {31'd0, bus.m_valid}, 32'd0);

    // Burst tagging with BURST_LEN=4 over 11 beats
    apply_reset();
    en = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 11; i++) push(8'h30 + 8'(i));
    #1;
    wait_valid("t3_first_valid", 5);
    for (int b = 1; b <= 11; b++) begin
      check("t3_data", {24'd0, bus.m_data}, 32'(8'h30 + b - 1));
      check("t3_last", {31'd0, bus.m_last}, (b % 4 == 0) ? 32'd1 : 32'd0);
      step();
    end
    check("t3_valid_end", {31'd0, bus.m_valid}, 32'd0);

    // Flush with a full buffer and a non-zero burst position
    apply_reset();
    en = 1'b1;
    bus.m_ready = 1'b1;
    push(8'hC0); push(8'hC1);
    #1;
    wait_valid("t4_pre_valid", 5);
    step();
    step();
    bus.m_ready = 1'b0;
    push(8'hB1); push(8'hB2); push(8'hB3);
    #1;
    step();
    step();
    check("t4_full_data", {24'd0, bus.m_data}, 32'hB1);
    check("t4_full_rinc", {31'd0, bus.rinc},   32'd0);
    flush = 1'b1;
    step();
    check("t4_flush_valid", {31'd0, bus.m_valid}, 32'd0);
    check("t4_flush_rinc",  {31'd0, bus.rinc},    32'd0);
    flush = 1'b0;
    #1;
    check("t4_resume_rinc", {31'd0, bus.rinc}, 32'd1);
    push(8'hD1); push(8'hD2); push(8'hD3);
    bus.m_ready = 1'b1;
    step();
    for (int b = 1; b <= 4; b++) begin
      check("t4_post_valid", {31'd0, bus.m_valid}, 32'd1);
      check("t4_post_last",  {31'd0, bus.m_last},  (b == 4) ? 32'd1 : 32'd0);
      step();
    end

    // Asynchronous reset mid-stream
    apply_reset();
    en = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
    #1;
    wait_valid("t5_first_valid", 5);
    step(); step(); step();
    bus.m_ready = 1'b0;
    #1;
    check("t5_pre_last", {31'd0, bus.m_last}, 32'd1);
    check("t5_pre_data", {24'd0, bus.m_data}, 32'h53);
    check("t5_pre_rinc", {31'd0, bus.rinc},   32'd1);
    rrst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, bus.m_valid}, 32'd0);
    check("t5_rst_last",  {31'd0, bus.m_last},  32'd0);
    check("t5_rst_rinc",  {31'd0, bus.rinc},    32'd0);
    step();
    rrst_n = 1'b1;
    step();
    check("t5_post_valid", {31'd0, bus.m_valid}, 32'd0);
    push(8'h5A);
    step();
    check("t5_fresh_data", {24'd0, bus.m_data}, 32'h5A);
    check("t5_fresh_last", {31'd0, bus.m_last}, 32'd0);

`ifdef FIFO_RD_STATS_EN
    // Statistics: 7 pops, 3 stall cycles, then flush
    apply_reset();
    check("t6_rst_pop",   pop_cnt,   32'd0);
    check("t6_rst_stall", stall_cnt, 32'd0);
    en = 1'b1;
    for (int i = 0; i < 7; i++) push(8'h70 + 8'(i));
    #1;
    step(); step(); step(); step();
    bus.m_ready = 1'b1;
    #1;
    for (int n = 0; n < 20 && bus.m_valid; n++) step();
    check("t6_pop",   pop_cnt,   32'd7);
    check("t6_stall", stall_cnt, 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_flush_pop",   pop_cnt,   32'd0);
    check("t6_flush_stall", stall_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
